// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: opcodes, funct3 codes,
// FSM state encoding and the registered memory request bundle.
package mem_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  // One data-memory request as presented on the mem_* port group.
  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [3:0]      wstrb;
  } mem_req_t;

  // Low address bits forced to the natural alignment of the access size
  // encoded in funct3[1:0] (00 byte, 01 half, 10 word).
  function automatic logic [1:0] align_lo(input logic [1:0] lo, input logic [1:0] sz);
    logic [1:0] r;
    r = lo;
    if (sz == 2'b01) r[0] = 1'b0;
    if (sz == 2'b10) r    = 2'b00;
    return r;
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: selects the addressed byte/halfword out of the read
// word and sign- or zero-extends it according to funct3.
module load_align
  import mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr_lo,
  input  logic [2:0]      funct3,
  output logic [XLEN-1:0] result
);

  logic [XLEN/8-1:0][7:0] lanes;
  logic [7:0]             byte_v;
  logic [15:0]            half_v;

  assign lanes  = rdata;
  assign byte_v = lanes[addr_lo];
  assign half_v = addr_lo[1] ? rdata[31:16] : rdata[15:0];

  // Extend the selected lane to the full register width.
  always_comb begin
    result = rdata;
    case (funct3)
      F3_B:    result = {{(XLEN-8){byte_v[7]}}, byte_v};
      F3_BU:   result = {{(XLEN-8){1'b0}}, byte_v};
      F3_H:    result = {{(XLEN-16){half_v[15]}}, half_v};
      F3_HU:   result = {{(XLEN-16){1'b0}}, half_v};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage. Loads/stores are issued to a single-port data memory
// over a req/ack handshake and stall upstream until acknowledged; all other
// results flow to write-back one cycle later.
// Optional feature macro: MEM_MISALIGN_TRAP_EN -- when defined, misaligned
// accesses are not issued and are flagged on the misaligned output; when
// undefined, the offending low address bits are forced to natural alignment.
module mem_stage
  import mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_in,
  input  logic [11:0]     operation,
  input  logic [XLEN-1:0] resultALU,
  input  logic [4:0]      address_rd,
  input  logic [XLEN-1:0] content_rs2,
  output logic            stall,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wstrb,
  input  logic            mem_ack,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            wb_valid,
  output logic            wb_we,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic            misaligned
`endif
);

  state_t          state, state_nx;
  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic            ld_ok, st_ok, ldst_opc, mem_op, go_mem;
  logic [1:0]      alo;
  mem_req_t        req_d;
  logic [2:0]      f3_q;
  logic [4:0]      rd_q;
  logic [1:0]      alo_q;
  logic [XLEN-1:0] ld_data;
  logic            unused_op_hi;

  assign opcode       = operation[6:0];
  assign f3           = operation[9:7];
  assign unused_op_hi = ^operation[11:10];

  // Decode: only the listed funct3 codes count as real memory operations.
  always_comb begin
    ldst_opc = (opcode == OPC_LOAD) || (opcode == OPC_STORE);
    ld_ok    = (opcode == OPC_LOAD)  && (f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    st_ok    = (opcode == OPC_STORE) && (f3 inside {F3_B, F3_H, F3_W});
    mem_op   = ld_ok || st_ok;
    alo      = align_lo(resultALU[1:0], f3[1:0]);
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic mis, trap;
  // Misaligned accesses are diverted to a trap write-back instead of memory.
  always_comb begin
    mis    = ((f3[1:0] == 2'b01) && resultALU[0]) ||
             ((f3[1:0] == 2'b10) && (resultALU[1:0] != 2'b00));
    go_mem = mem_op && !mis;
    trap   = mem_op && mis;
  end
`else
  assign go_mem = mem_op;
`endif

  // Build the store lane pattern from the (aligned) low address bits.
  always_comb begin
    req_d.we    = st_ok;
    req_d.addr  = {resultALU[XLEN-1:2], 2'b00};
    req_d.wdata = content_rs2;
    req_d.wstrb = 4'b0000;
    if (st_ok) begin
      case (f3[1:0])
        2'b00: begin
          req_d.wstrb = 4'b0001 << alo;
          req_d.wdata = {4{content_rs2[7:0]}};
        end
        2'b01: begin
          req_d.wstrb = alo[1] ? 4'b1100 : 4'b0011;
          req_d.wdata = {2{content_rs2[15:0]}};
        end
        default: req_d.wstrb = 4'b1111;
      endcase
    end
  end

  load_align #(.XLEN(XLEN)) u_load_align (
    .rdata   (mem_rdata),
    .addr_lo (alo_q),
    .funct3  (f3_q),
    .result  (ld_data)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Next state: enter WAIT on an issued access, leave on ack.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (valid_in && go_mem) state_nx = WAIT;
      WAIT:    if (mem_ack)            state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Stall output: held from issue until the ack cycle.
  always_comb begin
    stall = 1'b0;
    case (state)
      IDLE:    stall = valid_in && go_mem;
      WAIT:    stall = !mem_ack;
      default: stall = 1'b0;
    endcase
  end

  // Request/write-back registers; write-back flags are single-cycle pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      f3_q      <= '0;
      rd_q      <= '0;
      alo_q     <= '0;
      wb_valid  <= 1'b0;
      wb_we     <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      misaligned <= 1'b0;
`endif
    end else begin
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misaligned <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (valid_in) begin
            if (go_mem) begin
              mem_req   <= 1'b1;
              mem_we    <= req_d.we;
              mem_addr  <= req_d.addr;
              mem_wdata <= req_d.wdata;
              mem_wstrb <= req_d.wstrb;
              f3_q      <= f3;
              rd_q      <= address_rd;
              alo_q     <= alo;
            end
`ifdef MEM_MISALIGN_TRAP_EN
            else if (trap) begin
              wb_valid   <= 1'b1;
              wb_rd      <= address_rd;
              wb_data    <= '0;
              misaligned <= 1'b1;
            end
`endif
            else begin
              wb_valid <= 1'b1;
              wb_rd    <= address_rd;
              wb_data  <= resultALU;
              wb_we    <= (address_rd != 5'd0) && !ldst_opc;
            end
          end
        end
        WAIT: begin
          if (mem_ack) begin
            mem_req  <= 1'b0;
            wb_valid <= 1'b1;
            wb_rd    <= rd_q;
            wb_we    <= !mem_we && (rd_q != 5'd0);
            wb_data  <= mem_we ? '0 : ld_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Randomised scoreboard bench for mem_stage: a driver issues instructions
// and pushes expected memory requests and write-back entries; a memory
// responder and a write-back monitor pop and compare independently.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [11:0] operation;
  logic [31:0] resultALU, content_rs2;
  logic [4:0]  address_rd;
  logic        stall, mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic        wb_valid, wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
`ifdef MEM_MISALIGN_TRAP_EN
  logic        misaligned;
`endif

  always #5 clk = ~clk;

  mem_stage #(.XLEN(32)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .operation(operation),
    .resultALU(resultALU), .address_rd(address_rd), .content_rs2(content_rs2),
    .stall(stall), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data)
`ifdef MEM_MISALIGN_TRAP_EN
    , .misaligned(misaligned)
`endif
  );

  typedef struct {
    logic        we;
    logic [31:0] addr, wdata, rdata;
    logic [3:0]  wstrb;
    int          delay;
  } mexp_t;

  typedef struct {
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        chk_data;
    logic        mis;
  } wexp_t;

  mexp_t mq[$];
  wexp_t wq[$];
  int checks = 0, errors = 0;
  bit resp_en = 1'b1, man_ack = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: derive the expected memory request and write-back
  // entry from the instruction fields with plain arithmetic.
  task automatic predict(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] rs2, input logic [4:0] rd, input logic [31:0] rdata,
                         input int delay, output int nstall);
    bit is_ld, is_st, mis;
    int size, off;
    logic [31:0] ea, mask, v;
    mexp_t m;
    wexp_t w;
    is_ld = (opc == 7'h03) && (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    is_st = (opc == 7'h23) && (f3 <= 2);
    nstall = 0;
    w.mis = 1'b0; w.chk_data = 1'b1; w.rd = rd;
    if (!(is_ld || is_st)) begin
      w.we = (rd != 0) && (opc != 7'h03) && (opc != 7'h23);
      w.data = addr;
      wq.push_back(w);
      return;
    end
    size = 1 << f3[1:0];
    mis  = (addr % size) != 0;
`ifdef MEM_MISALIGN_TRAP_EN
    if (mis) begin
      w.we = 1'b0; w.data = 0; w.chk_data = 1'b0; w.mis = 1'b1;
      wq.push_back(w);
      return;
    end
`endif
    ea   = addr - (addr % size);
    off  = ea % 4;
    mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 1);
    m.addr = ea & ~32'd3; m.delay = delay; m.rdata = rdata;
    if (is_st) begin
      m.we = 1'b1;
      m.wdata = (size == 1) ? (rs2 & 32'hFF) * 32'h0101_0101 :
                (size == 2) ? (rs2 & 32'hFFFF) * 32'h0001_0001 : rs2;
      m.wstrb = 4'(((1 << size) - 1) << off);
      w.we = 1'b0; w.data = 0;
    end else begin
      m.we = 1'b0; m.wdata = 0; m.wstrb = 0;
      v = (rdata >> (8 * off)) & mask;
      if (size < 4 && f3[2] == 1'b0 && v[8 * size - 1]) v = v | ~mask;
      w.we = (rd != 0); w.data = v;
    end
    mq.push_back(m);
    wq.push_back(w);
    nstall = 1 + delay;
  endtask

  // Present one instruction and hold it until the stage stops stalling.
  task automatic issue(input logic [6:0] opc, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] rs2, input logic [4:0] rd, input logic [31:0] rdata,
                       input int delay);
    int nst, st, cyc;
    bit done;
    @(posedge clk); #1;
    valid_in = 1'b1;
    operation = {2'($urandom), f3, opc};
    resultALU = addr; content_rs2 = rs2; address_rd = rd;
    predict(opc, f3, addr, rs2, rd, rdata, delay, nst);
    st = 0; cyc = 0; done = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      if (stall) st++; else done = 1;
      cyc++;
    end
    if (!done) begin
      errors++; checks++;
      $display("FAIL stall_timeout: stall still high after %0d cycles", cyc);
    end
    chk("stall_cycles", st, nst);
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    valid_in = 1'b0;
    operation = 12'($urandom); resultALU = $urandom; address_rd = 5'($urandom);
    repeat (n) @(posedge clk);
  endtask

  // Memory responder: checks each request cycle and acks after its delay.
  initial begin : responder
    mexp_t cur;
    bit pend = 1'b0;
    int cnt = 0;
    mem_ack = 1'b0; mem_rdata = 0;
    forever begin
      @(posedge clk); #2;
      mem_ack = 1'b0;
      mem_rdata = $urandom;
      if (!resp_en) begin
        mem_ack = man_ack;
        pend = 1'b0;
      end else if (mem_req) begin
        if (!pend) begin
          if (mq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_mem_req: addr %h with no access expected", mem_addr);
          end else begin
            cur = mq.pop_front(); pend = 1'b1; cnt = cur.delay;
          end
        end
        if (pend) begin
          chk("mem_we", mem_we, cur.we);
          chk("mem_addr", mem_addr, cur.addr);
          if (cur.we) begin
            chk("mem_wdata", mem_wdata, cur.wdata);
            chk("mem_wstrb", mem_wstrb, cur.wstrb);
          end
          if (cnt == 0) begin
            mem_ack = 1'b1; mem_rdata = cur.rdata; pend = 1'b0;
          end else cnt--;
        end
      end
    end
  end

  // Write-back monitor: every wb_valid pulse consumes one expected entry.
  initial begin : monitor
    wexp_t e;
    forever begin
      @(negedge clk);
      if (wb_valid) begin
        if (wq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_wb: rd %0d data %h with no entry expected", wb_rd, wb_data);
        end else begin
          e = wq.pop_front();
          chk("wb_we", wb_we, e.we);
          chk("wb_rd", wb_rd, e.rd);
          if (e.chk_data) chk("wb_data", wb_data, e.data);
`ifdef MEM_MISALIGN_TRAP_EN
          chk("misaligned", misaligned, e.mis);
`endif
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic [6:0] pool [5];
    logic [6:0] opc;
    reset = 1'b1; valid_in = 1'b0; operation = 0; resultALU = 0;
    content_rs2 = 0; address_rd = 0;
    pool[0] = 7'h03; pool[1] = 7'h23; pool[2] = 7'h33; pool[3] = 7'h13; pool[4] = 7'h03;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", mem_req, 0);   chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0); chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_wstrb", mem_wstrb, 0);
    chk("rst_wb_valid", wb_valid, 0); chk("rst_wb_we", wb_we, 0);
    chk("rst_wb_rd", wb_rd, 0);       chk("rst_wb_data", wb_data, 0);
    chk("rst_stall", stall, 0);
    reset = 1'b0;

    // Directed cases
    issue(7'h33, 3'd0, 32'h0000_1234, 32'h0, 5'd5, 32'h0, 0);
    issue(7'h23, 3'd0, 32'h0000_0103, 32'hAABB_CCDD, 5'd7, 32'h0, 3);
    issue(7'h03, 3'd0, 32'h0000_0202, 32'h0, 5'd3, 32'h0080_0000, 0);
    issue(7'h03, 3'd4, 32'h0000_0202, 32'h0, 5'd4, 32'h0080_0000, 0);
    issue(7'h03, 3'd0, 32'h0000_0202, 32'h0, 5'd0, 32'h0080_0000, 0);
    issue(7'h03, 3'd1, 32'h0000_0002, 32'h0, 5'd8, 32'h8001_0000, 1);
    issue(7'h03, 3'd2, 32'h0000_0004, 32'h0, 5'd9, 32'hDEAD_BEEF, 2);
    issue(7'h03, 3'd2, 32'h0000_0006, 32'h0, 5'd10, 32'h1357_9BDF, 0);
    issue(7'h23, 3'd1, 32'h0000_0102, 32'h1234_5678, 5'd1, 32'h0, 1);
    issue(7'h23, 3'd1, 32'h0000_0101, 32'h1234_5678, 5'd1, 32'h0, 0);
    issue(7'h23, 3'd2, 32'h0000_0102, 32'hCAFE_F00D, 5'd1, 32'h0, 0);
    issue(7'h03, 3'd5, 32'h0000_0012, 32'h0, 5'd11, 32'h8765_4321, 0);
    issue(7'h03, 3'd3, 32'h0000_0040, 32'h0, 5'd12, 32'h0, 0);
    issue(7'h23, 3'd4, 32'h0000_0044, 32'h0, 5'd13, 32'h0, 0);
    idle(2);

    // Randomised traffic
    for (int i = 0; i < 300; i++) begin
      opc = ($urandom_range(0, 9) == 0) ? 7'($urandom) : pool[$urandom_range(0, 4)];
      issue(opc, 3'($urandom), $urandom, $urandom, 5'($urandom), $urandom,
            $urandom_range(0, 4));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 2));
    end
    idle(3);

    // Reset while an access is outstanding; a late ack must be ignored.
    resp_en = 1'b0;
    @(posedge clk); #1;
    valid_in = 1'b1; operation = {2'b00, 3'd2, 7'h03};
    resultALU = 32'h40; address_rd = 5'd6;
    @(negedge clk); chk("rw_stall_issue", stall, 1);
    @(posedge clk); #1;
    @(negedge clk); chk("rw_mem_req", mem_req, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1; valid_in = 1'b0;
    #2 man_ack = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rw_ack_mem_req", mem_req, 0);
    chk("rw_ack_stall", stall, 0);
    chk("rw_ack_wb_valid", wb_valid, 0);
    man_ack = 1'b0;
    @(negedge clk);
    chk("rw_after_wb_valid", wb_valid, 0);
    chk("rw_after_mem_req", mem_req, 0);
    resp_en = 1'b1;

    // Recovery after the abandoned access
    issue(7'h03, 3'd2, 32'h0000_0080, 32'h0, 5'd14, 32'h0BAD_F00D, 1);
    issue(7'h13, 3'd0, 32'h0000_0055, 32'h0, 5'd15, 32'h0, 0);
    idle(5);
    chk("wb_queue_empty", wq.size(), 0);
    chk("mem_queue_empty", mq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the in-order pipeline; sits directly downstream of the execute stage and consumes its resultALU, address_rd and content_rs2.
- Loads and stores go to a single-port data memory over a req/ack handshake; the stage stalls upstream while an access is outstanding.
- Non-memory results pass straight through to write-back with 1-cycle latency.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- valid_in  in  1  execute output holds a valid instruction
- operation  in  12  [9:7] funct3, [6:0] opcode; [11:10] ignored
- resultALU  in  XLEN  effective address (load/store) or result (other ops)
- address_rd  in  5  destination register
- content_rs2  in  XLEN  store data
- stall  out  1  upstream must hold its outputs
- mem_req  out  1  access request, held until ack
- mem_we  out  1  1 = store
- mem_addr  out  XLEN  word-aligned address ({resultALU[31:2],2'b00})
- mem_wdata  out  XLEN  lane-replicated store data
- mem_wstrb  out  4  byte enables
- mem_ack  in  1  access complete; mem_rdata valid in the same cycle for loads
- mem_rdata  in  XLEN  read word
- wb_valid  out  1  write-back entry valid, 1-cycle pulse per instruction
- wb_we  out  1  register write enable
- wb_rd  out  5  destination register
- wb_data  out  XLEN  write-back value

Behaviour:
- Reset: state=IDLE; mem_req, mem_we, wb_valid, wb_we = 0; mem_addr, mem_wdata, wb_data = 0; mem_wstrb = 0; wb_rd = 0. A reset during WAIT abandons the access. A mem_ack arriving after reset is ignored.
- Decode:
  - LOAD opcode 0000011: funct3 LB 000, LH 001, LW 010, LBU 100, LHU 101.
  - STORE opcode 0100011: funct3 SB 000, SH 001, SW 010.
  - Any other opcode is a pass-through.
- IDLE state:
  - valid_in with a pass-through: at the next edge, wb_valid=1, wb_data=resultALU, wb_rd=address_rd, wb_we=(address_rd!=0).
  - valid_in with a load/store: stall=1 combinationally. At the edge, register mem_req=1, mem_we, mem_addr, mem_wdata, mem_wstrb, funct3, rd and addr[1:0], then go to WAIT. wb_valid=0 in that cycle.
  - valid_in=0: wb_valid=0.
- WAIT state:
  - Inputs are ignored. stall=1 while mem_ack=0. mem_* outputs are held stable.
  - When mem_ack=1: stall=0 in that cycle. At the edge: mem_req=0, state=IDLE, wb_valid=1, wb_rd=rd.
  - Load at ack: wb_we=(rd!=0), wb_data=aligned/extended mem_rdata.
  - Store at ack: wb_we=0, wb_data=0.
- Minimum mem-op latency: valid_in at cycle 0, mem_req at cycle 1, ack at cycle 1 at the earliest, wb_valid at cycle 2.
- Store lanes:
  - SB: wstrb = 1<<addr[1:0], wdata = {4{rs2[7:0]}}.
  - SH: wstrb = addr[1] ? 1100 : 0011, wdata = {2{rs2[15:0]}}.
  - SW: wstrb = 1111, wdata = rs2.
- Load extraction: select byte/half by addr[1:0]. Sign-extend for LB/LH, zero-extend for LBU/LHU.
- Misalignment: SH/LH/LHU with addr[0]=1, or SW/LW with addr[1:0]!=0. Handling depends on the optional feature below.
- Unsupported funct3 on LOAD/STORE is treated as a pass-through with wb_we=0.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined:
  - Adds output port misaligned (1 bit, reset 0).
  - A misaligned access issues no mem_req and does not stall.
  - Next edge: wb_valid=1, wb_we=0, misaligned=1 pulse for one cycle, wb_rd=address_rd.
- Undefined:
  - No port.
  - The offending low address bits are forced to the natural alignment (halfword: addr[0]=0; word: addr[1:0]=0) and the access proceeds normally.

Decomposition:
- Shared package mem_pkg: OPC_LOAD/OPC_STORE constants, funct3 constants (F3_B, F3_H, F3_W, F3_BU, F3_HU), state enum {IDLE, WAIT}.
- One sub-module, load_align: combinational mem_rdata + addr[1:0] + funct3 -> XLEN result.

Test Plan:
- Pass-through: valid_in, opcode 0110011, resultALU=0x0000_1234, rd=5 -> next cycle wb_valid=1, wb_data=0x1234, wb_we=1; no mem_req.
- SB: resultALU=0x103, rs2=0xAABBCCDD, ack 3 cycles after req -> mem_addr=0x100, wstrb=1000, wdata=0xDDDDDDDD; stall high until the ack cycle; then wb_valid=1, wb_we=0.
- LB/LBU: addr 0x202, mem_rdata=0x0080_0000, immediate ack -> LB wb_data=0xFFFFFF80, LBU wb_data=0x00000080; rd=0 gives wb_we=0.
- LH: addr 0x2, rdata=0x8001_0000 -> wb_data=0xFFFF8001; LW addr 0x4 -> wb_data=rdata unchanged.
- Reset in WAIT: assert reset 2 cycles after mem_req, with ack in the following cycle -> mem_req=0, wb_valid stays 0, stall=0, state IDLE.
- With MEM_MISALIGN_TRAP_EN, LW at 0x6 -> no mem_req, next cycle misaligned=1, wb_valid=1, wb_we=0. Without the macro -> mem_addr=0x4, normal load.
